// File: rtl/lock_pkg.sv
// Shared types for the combination-lock mode controller: mode encodings
// (also decoded by the LED logic) and the BCD digit type.
package lock_pkg;

  typedef enum logic [1:0] {
    MODE_SET     = 2'b00,
    MODE_LOCKED  = 2'b01,
    MODE_LOCKOUT = 2'b10,
    MODE_OPEN    = 2'b11
  } mode_e;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: free-running 0..TICKS_PER_SEC-1, tick is high in the
// cycle the counter wraps; restart forces the count back to zero.
module sec_tick #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lock_sequencer.sv
// Lock mode controller: SET / LOCKED / LOCKOUT / OPEN sequencing, failed-attempt
// counting, escalating BCD lockout countdown and idle relock of an open lock.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter int unsigned BASE_LOCK_SEC = 10,
  parameter int unsigned MAX_LOCK_SEC  = 90,
  parameter int unsigned IDLE_SEC      = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       submit,
  input  logic       match,
  input  logic       change_req,
  input  logic       key_activity,
  output logic [1:0] mode,
  output logic       clr_pw,
  output logic       clr_guess,
  output logic [1:0] attempts_left,
  output bcd_t       lock_tens,
  output bcd_t       lock_ones,
  output logic       lock_active
);

  localparam int unsigned IW = $clog2(IDLE_SEC + 1);
  localparam logic [1:0]    ATT_INIT = 2'(MAX_ATTEMPTS);
  localparam logic [6:0]    DUR_BASE = 7'(BASE_LOCK_SEC);
  localparam logic [7:0]    DUR_MAX  = 8'(MAX_LOCK_SEC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SEC - 1);

  mode_e         mode_q, mode_d;
  logic [1:0]    att_q, att_d;
  bcd_t          tens_q, tens_d, ones_q, ones_d;
  logic [6:0]    dur_q, dur_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          pend_q;
  logic          clr_pw_q, clr_pw_d;
  logic          clr_guess_q, clr_guess_d;
  logic          lock_act_q, lock_act_d;
  logic          restart, tick;
  logic [7:0]    dur_dbl;
  logic [6:0]    dur_next;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  sec_tick #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  assign dur_dbl  = {dur_q, 1'b0};
  assign dur_next = (dur_dbl > DUR_MAX) ? DUR_MAX[6:0] : dur_dbl[6:0];

  always_comb begin
    mode_d      = mode_q;
    att_d       = att_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    dur_d       = dur_q;
    idle_d      = idle_q;
    clr_pw_d    = pend_q;
    clr_guess_d = 1'b0;
    restart     = 1'b0;

    unique case (mode_q)
      MODE_SET: begin
        if (submit) begin
          mode_d      = MODE_LOCKED;
          att_d       = ATT_INIT;
          clr_guess_d = 1'b1;
        end
      end
      MODE_LOCKED: begin
        if (submit) begin
          clr_guess_d = 1'b1;
          if (match) begin
            mode_d  = MODE_OPEN;
            att_d   = '0;
            dur_d   = DUR_BASE;
            idle_d  = '0;
            restart = 1'b1;
          end else if (att_q > 2'd1) begin
            att_d = att_q - 2'd1;
          end else begin
            mode_d           = MODE_LOCKOUT;
            att_d            = '0;
            {tens_d, ones_d} = to_bcd(dur_q);
            dur_d            = dur_next;
            restart          = 1'b1;
          end
        end
      end
      MODE_LOCKOUT: begin
        // 00 is held for one cycle, then the lock returns to LOCKED
        if (tens_q == 4'd0 && ones_q == 4'd0) begin
          mode_d      = MODE_LOCKED;
          att_d       = ATT_INIT;
          clr_guess_d = 1'b1;
        end else if (tick) begin
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end
      MODE_OPEN: begin
        if (change_req) begin
          mode_d   = MODE_SET;
          clr_pw_d = 1'b1;
        end else if (submit) begin
          mode_d      = MODE_LOCKED;
          att_d       = ATT_INIT;
          clr_guess_d = 1'b1;
        end else if (key_activity) begin
          idle_d = '0;
        end else if (tick) begin
          if (idle_q == IDLE_LAST) begin
            mode_d      = MODE_LOCKED;
            att_d       = ATT_INIT;
            clr_guess_d = 1'b1;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      default: mode_d = MODE_SET;
    endcase

    lock_act_d = (mode_d == MODE_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_SET;
      att_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      dur_q       <= DUR_BASE;
      idle_q      <= '0;
      pend_q      <= 1'b1;
      clr_pw_q    <= 1'b0;
      clr_guess_q <= 1'b0;
      lock_act_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      att_q       <= att_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      dur_q       <= dur_d;
      idle_q      <= idle_d;
      pend_q      <= 1'b0;
      clr_pw_q    <= clr_pw_d;
      clr_guess_q <= clr_guess_d;
      lock_act_q  <= lock_act_d;
    end
  end

  assign mode          = mode_q;
  assign clr_pw        = clr_pw_q;
  assign clr_guess     = clr_guess_q;
  assign attempts_left = att_q;
  assign lock_tens     = tens_q;
  assign lock_ones     = ones_q;
  assign lock_active   = lock_act_q;

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
Mode controller for the combination lock. It sequences password-set, locked, lockout and open phases. It counts failed attempts, runs an escalating lockout countdown with BCD output for the seven-segment digits, and relocks an open lock after an idle timeout. It drives the clear strobes for the password and guess registers and receives the comparator result from the checker array.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per one-second tick
MAX_ATTEMPTS, 3, failed submits allowed before lockout (1..3)
BASE_LOCK_SEC, 10, first lockout duration in seconds (1..99)
MAX_LOCK_SEC, 90, lockout duration saturation value (BASE_LOCK_SEC..99)
IDLE_SEC, 30, seconds without key activity in OPEN before relock

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
submit  in  1  one-cycle pulse, edge-detected confirm button
match  in  1  AND of all digit checkers, valid in the cycle submit is high
change_req  in  1  one-cycle pulse requesting a password change, honoured only in OPEN
key_activity  in  1  one-cycle pulse on any button or switch-commit edge
mode  out  2  00 SET, 01 LOCKED, 10 LOCKOUT, 11 OPEN
clr_pw  out  1  one-cycle strobe that zeroes the password digits
clr_guess  out  1  one-cycle strobe that zeroes the guess digits
attempts_left  out  2  remaining attempts in LOCKED, 0 in other modes
lock_tens  out  4  BCD tens digit of lockout seconds remaining
lock_ones  out  4  BCD ones digit of lockout seconds remaining
lock_active  out  1  high while mode is LOCKOUT

Behaviour:
- Reset: asynchronous, active-low. While reset is asserted:
  - mode=SET, clr_pw=0, clr_guess=0, attempts_left=0, lock_tens/ones=0, lock_active=0.
  - Lockout duration register = BASE_LOCK_SEC. Prescaler = 0.
  - A pending-entry flag is set so that clr_pw pulses in the first clock after rst_n deasserts.
- All outputs are registered. Mode changes one cycle after the causing pulse. A strobe goes high in the same cycle as the new mode value.
- SET:
  - submit -> LOCKED, clr_guess=1, attempts_left=MAX_ATTEMPTS.
  - match is ignored.
- LOCKED:
  - submit with match=1 -> OPEN, clr_guess=1. Lockout duration resets to BASE_LOCK_SEC. Idle counter cleared.
  - submit with match=0 and attempts_left>1 -> stay in LOCKED, decrement attempts_left, clr_guess=1.
  - submit with match=0 and attempts_left==1 -> LOCKOUT, clr_guess=1.
  - On LOCKOUT entry:
    - load lock_tens/ones with BCD of the current duration;
    - restart the prescaler so the first second is a full TICKS_PER_SEC;
    - then set duration = min(2*duration, MAX_LOCK_SEC) for the next lockout.
- LOCKOUT:
  - submit, change_req and match are ignored.
  - Each tick decrements the BCD pair with ones borrow: 20 -> 19, 10 -> 09.
  - The tick that makes the value 00 -> LOCKED, attempts_left=MAX_ATTEMPTS, clr_guess=1, lock_active=0.
  - Exit happens in the cycle after the 01 -> 00 tick, so 00 is displayed for exactly 1 cycle.
- OPEN:
  - change_req -> SET, clr_pw=1.
  - submit -> LOCKED, clr_guess=1, attempts_left=MAX_ATTEMPTS.
  - Idle counter (seconds) clears on key_activity and advances on tick. Reaching IDLE_SEC -> LOCKED, as for submit.
- Simultaneous events:
  - In OPEN, change_req beats submit, and both beat idle timeout.
  - key_activity in the same cycle as the timeout tick clears the counter and cancels the timeout.
- Lockout duration is not reset by any path other than a correct unlock or rst_n. Escalation therefore persists across LOCKED -> LOCKOUT cycles.
- Prescaler: free-running counter 0..TICKS_PER_SEC-1. The tick is the cycle it wraps. It restarts on LOCKOUT entry and on OPEN entry.
- rst_n asserted mid-lockout or mid-open returns immediately to the SET reset state. Any countdown is lost.

Decomposition:
- Shared package lock_pkg holds:
  - mode encodings MODE_SET/MODE_LOCKED/MODE_LOCKOUT/MODE_OPEN (2'b00/01/10/11), which the LED decode uses;
  - BCD digit type (4 bits).
- Sub-module sec_tick (parameter TICKS_PER_SEC; ports clk, rst_n, restart, tick) is the natural split, reused for the idle timer and the countdown.
- The binary-to-BCD load of a value ≤99 is a local function.

Test Plan:
- Reset release -> clr_pw high for exactly 1 cycle, mode=00. submit -> mode=01, attempts_left=3, clr_guess pulse.
- TICKS_PER_SEC=4, BASE=10. Three submits with match=0 -> attempts_left 3,2,1 then mode=10, lock=1,0. After 40 cycles, digits step 10,09..01,00, then mode=01, attempts_left=3.
- Second lockout without an intervening unlock -> loads 20. Third -> 40. Force BASE=50, MAX=90 -> second load saturates at 90.
- submit match=1 -> mode=11. Next lockout loads 10 again. In LOCKOUT, submit with match=1 -> no change.
- OPEN, IDLE_SEC=3, TICKS=4 -> no key_activity for 12 cycles relocks to 01. key_activity at cycle 11 -> remains 11.
- OPEN, change_req and submit in the same cycle -> mode=00, clr_pw=1, clr_guess=0. rst_n low mid-lockout -> outputs at reset values asynchronously.
